// File: rtl/spi_slave_if_if.sv
// Bus bundle between the SPI slave front-end and its master side (pins plus RAM handshake).
interface spi_slave_if_if #(
  parameter int RX_W = 10,
  parameter int TX_W = 8
);
  logic            SS_n;
  logic            MOSI;
  logic            MISO;
  logic [RX_W-1:0] rx_data;
  logic            rx_valid;
  logic [TX_W-1:0] tx_data;
  logic            tx_valid;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave: deserialises 10-bit {cmd,payload} frames for the RAM and
// shifts the RAM read byte back out on MISO.
//
// state     | meaning
// IDLE      | SS_n high, waiting for select
// CHK_CMD   | sampling frame bit 9, picking write / read-addr / read-data path
// WRITE     | shifting bits 8..0 of a write-address or write-data frame
// READ_ADD  | shifting bits 8..0 of a read-address frame
// READ_DATA | shifting bits 8..0, then capturing tx_data and shifting it out
module spi_slave_if #(
  parameter int RX_W = 10,
  parameter int TX_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  spi_slave_if_if.slave  bus
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CHK_CMD   = 3'd1;
  localparam logic [2:0] WRITE     = 3'd2;
  localparam logic [2:0] READ_ADD  = 3'd3;
  localparam logic [2:0] READ_DATA = 3'd4;

  localparam int CNT_W = $clog2(RX_W);
  localparam int TXC_W = $clog2(TX_W);

  logic [2:0]      state;
  logic [CNT_W-1:0] bit_cnt;
  logic [RX_W-2:0] rx_shift;
  logic            frame_done;
  logic            rd_addr_done;
  logic            tx_captured;
  logic [TX_W-2:0] tx_shift;
  logic [TXC_W-1:0] tx_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      rx_shift     <= '0;
      frame_done   <= 1'b0;
      rd_addr_done <= 1'b0;
      tx_captured  <= 1'b0;
      tx_shift     <= '0;
      tx_cnt       <= '0;
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
      bus.MISO     <= 1'b0;
    end else begin
      bus.rx_valid <= 1'b0;
      bus.MISO     <= 1'b0;
      // Deselect wins over everything; rd_addr_done deliberately survives an abort.
      if (bus.SS_n) begin
        state       <= IDLE;
        bit_cnt     <= '0;
        frame_done  <= 1'b0;
        tx_captured <= 1'b0;
        tx_cnt      <= '0;
      end else begin
        case (state)
          IDLE: state <= CHK_CMD;
          CHK_CMD: begin
            rx_shift    <= {rx_shift[RX_W-3:0], bus.MOSI};
            bit_cnt     <= CNT_W'(RX_W - 2);
            frame_done  <= 1'b0;
            tx_captured <= 1'b0;
            tx_cnt      <= '0;
            if (!bus.MOSI)        state <= WRITE;
            else if (rd_addr_done) state <= READ_DATA;
            else                   state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (!frame_done) begin
              rx_shift <= {rx_shift[RX_W-3:0], bus.MOSI};
              if (bit_cnt == '0) begin
                bus.rx_data  <= {rx_shift, bus.MOSI};
                bus.rx_valid <= 1'b1;
                frame_done   <= 1'b1;
                if (state == READ_ADD) rd_addr_done <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt - 1'b1;
              end
            end else if (state == READ_DATA) begin
              // One capture per frame; later tx_valid cycles are ignored.
              if (!tx_captured) begin
                if (bus.tx_valid) begin
                  tx_captured  <= 1'b1;
                  tx_shift     <= bus.tx_data[TX_W-2:0];
                  tx_cnt       <= TXC_W'(TX_W - 1);
                  bus.MISO     <= bus.tx_data[TX_W-1];
                  rd_addr_done <= 1'b0;
                end
              end else if (tx_cnt != '0) begin
                bus.MISO <= tx_shift[TX_W-2];
                tx_shift <= tx_shift << 1;
                tx_cnt   <= tx_cnt - 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
